exotiny_mem_arb: RTL and testbench
==================================

Name: exotiny_mem_arb

Overview:
- Sequential Wishbone arbiter sharing the single QSPI memory controller between the FazyRV instruction port and data port.
- Sits between the CPU and the QSPI memory controller, replacing the combinational imem-priority mux.
- Holds a registered grant for the whole transaction until the downstream ack.
- Supports round-robin or fixed instruction priority.

Parameters:
- RR, 1: 1 = round-robin between imem and dmem; 0 = fixed imem priority.
- TIMEOUT, 255: cycles without downstream ack before forced termination (used only with the optional feature); range 1..255.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- imem_stb_i  in  1  instruction request
- imem_adr_i  in  32  instruction address
- imem_ack_o  out  1  instruction ack
- imem_dat_o  out  32  instruction read data
- dmem_stb_i  in  1  data request
- dmem_we_i  in  1  data write enable
- dmem_be_i  in  4  data byte enables
- dmem_adr_i  in  32  data address
- dmem_dat_i  in  32  data write data
- dmem_ack_o  out  1  data ack
- dmem_dat_o  out  32  data read data
- mem_stb_o  out  1  downstream strobe
- mem_we_o  out  1  downstream write enable
- mem_be_o  out  4  downstream byte enables
- mem_adr_o  out  32  downstream address
- mem_dat_o  out  32  downstream write data
- mem_dat_i  in  32  downstream read data
- mem_ack_i  in  1  downstream ack
- gnt_o  out  2  current grant: [0] = imem, [1] = dmem; one-hot or zero
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset (asynchronous, rst_i=1):
  - state=IDLE, gnt_o=0, err_o=0.
  - last=DMEM, so imem wins the first contested arbitration (boot fetch).
  - mem_stb_o=0, imem_ack_o=0, dmem_ack_o=0.
  - Data and address outputs are 0 while no grant is held.
- States: IDLE, GNT_I, GNT_D.
- IDLE transitions:
  - Only imem_stb_i -> GNT_I.
  - Only dmem_stb_i -> GNT_D.
  - Both requesting, RR=1 -> grant the port not equal to last.
  - Both requesting, RR=0 -> GNT_I.
  - Neither requesting -> stay in IDLE.
  - last is updated on every grant.
- Arbitration latency: 1 cycle from request to mem_stb_o. No downstream strobe is issued in IDLE.
- GNT_I drive:
  - mem_stb_o = imem_stb_i, mem_we_o = 0, mem_be_o = 4'hF, mem_adr_o = imem_adr_i, mem_dat_o = 0.
- GNT_D drive:
  - mem_stb_o = dmem_stb_i, mem_we_o = dmem_we_i, mem_be_o = dmem_be_i, mem_adr_o = dmem_adr_i, mem_dat_o = dmem_dat_i.
- Ack and read data routing:
  - The ack is routed combinationally to the granted port only: imem_ack_o = gnt_o[0] & imem_stb_i & mem_ack_i; dmem ack likewise.
  - The non-granted port ack is always 0.
  - imem_dat_o and dmem_dat_o both carry mem_dat_i.
- Grant release:
  - A downstream ack in a GNT state -> IDLE next cycle. A mandatory idle cycle follows, so no double issue while the acked master's stb is still high.
  - Granted master deasserts stb before ack (abort) -> mem_stb_o drops that cycle, IDLE next cycle. A late mem_ack_i arriving while in IDLE is ignored.
- Simultaneous events:
  - mem_ack_i in IDLE is ignored.
  - A new request arriving in the ack cycle is arbitrated in the following IDLE cycle.
- Starvation: with RR=1 and both ports continuously requesting, grants strictly alternate I, D, I, D, and so on.

Optional Feature:
- Macro: EXOTINY_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit counter clears on entry to GNT_I or GNT_D and increments each GNT cycle without mem_ack_i.
  - When the counter equals TIMEOUT: the granted port receives a 1-cycle ack with read data 32'h0 and mem_stb_o is forced to 0 that cycle.
  - err_o is set and stays set until reset; state goes to IDLE.
- Without the macro:
  - No counter is built and err_o is tied to 0.
  - A grant is held indefinitely until ack or abort.

Test Plan:
- Reset, then imem_stb_i=1 with adr 0x10000000 and ack on the 3rd cycle after grant -> gnt_o=01 one cycle after the request; mem_be_o=F, mem_we_o=0; imem_ack_o pulses once with data 0x00000013; an idle cycle follows.
- imem and dmem requesting together from reset, RR=1 -> grant order I, D, I, D over 4 transactions.
- Same stimulus with RR=0 -> imem granted every arbitration; dmem is served only when imem_stb_i=0.
- dmem write adr 0x00000040, dat 0xCAFEBABE, be=0011 during an ongoing imem transaction -> no mem_stb_o change until the imem ack; then GNT_D with mem_we_o=1, be=0011, dat=0xCAFEBABE; imem_ack_o=0 during the dmem ack.
- Granted dmem drops stb before ack, then mem_ack_i arrives a cycle later -> mem_stb_o=0 immediately; state is IDLE; no ack reaches either port.
- EXOTINY_ARB_TIMEOUT_EN defined, TIMEOUT=8, no mem_ack_i -> dmem_ack_o pulses on the 8th grant cycle with data 0; err_o=1 and stays 1; the next request is still granted normally.

Source files
------------

// File: rtl/exotiny_mem_arb.sv
// Sequential Wishbone arbiter: FazyRV imem/dmem onto one QSPI controller, grant held until ack or abort.
// Define EXOTINY_ARB_TIMEOUT_EN to build the no-ack watchdog (TIMEOUT cycles, sticky err_o).
module exotiny_mem_arb #(
  parameter int RR      = 1,
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_stb_i,
  input  logic [31:0] imem_adr_i,
  output logic        imem_ack_o,
  output logic [31:0] imem_dat_o,
  input  logic        dmem_stb_i,
  input  logic        dmem_we_i,
  input  logic [3:0]  dmem_be_i,
  input  logic [31:0] dmem_adr_i,
  input  logic [31:0] dmem_dat_i,
  output logic        dmem_ack_o,
  output logic [31:0] dmem_dat_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  input  logic [31:0] mem_dat_i,
  input  logic        mem_ack_i,
  output logic [1:0]  gnt_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;  // 1: dmem held the most recent grant
  logic [1:0]  gnt_q, gnt_d;
  logic        gnt_stb;
  logic        to_hit;
  logic [31:0] rd_dat;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("exotiny_mem_arb: TIMEOUT must be within 1..255");
  end

  assign gnt_stb = (gnt_q[0] & imem_stb_i) | (gnt_q[1] & dmem_stb_i);

`ifdef EXOTINY_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // Fires in the TIMEOUT-th grant cycle that still has no downstream ack.
  assign to_hit = gnt_stb & ~mem_ack_i & (cnt_q == TO_LAST);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | to_hit;
    if (state_q == IDLE) begin
      cnt_d = 8'd0;
    end else if (!mem_ack_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign to_hit = 1'b0;
  assign err_o  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (imem_stb_i && (!dmem_stb_i || RR == 0 || last_q)) begin
          state_d = GNT_I;
        end else if (dmem_stb_i) begin
          state_d = GNT_D;
        end
        if (state_d != IDLE) begin
          last_d = (state_d == GNT_D);
        end
      end
      // Abort, ack and timeout all release; the following IDLE cycle blocks a double issue.
      GNT_I: if (!imem_stb_i || mem_ack_i || to_hit) state_d = IDLE;
      GNT_D: if (!dmem_stb_i || mem_ack_i || to_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    gnt_d = {state_d == GNT_D, state_d == GNT_I};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign mem_stb_o = gnt_stb & ~to_hit;
  assign mem_we_o  = gnt_q[1] & dmem_we_i;
  assign mem_be_o  = gnt_q[0] ? 4'hF : (gnt_q[1] ? dmem_be_i : 4'h0);
  assign mem_adr_o = gnt_q[0] ? imem_adr_i : (gnt_q[1] ? dmem_adr_i : 32'h0);
  assign mem_dat_o = gnt_q[1] ? dmem_dat_i : 32'h0;

  assign rd_dat     = ((gnt_q != 2'b00) && !to_hit) ? mem_dat_i : 32'h0;
  assign imem_dat_o = rd_dat;
  assign dmem_dat_o = rd_dat;
  assign imem_ack_o = gnt_q[0] & imem_stb_i & (mem_ack_i | to_hit);
  assign dmem_ack_o = gnt_q[1] & dmem_stb_i & (mem_ack_i | to_hit);

endmodule

// File: tb/tb_exotiny_mem_arb.sv
// Bench for exotiny_mem_arb: two instances (RR=1, RR=0) checked each cycle against a transaction-level model.
module tb_exotiny_mem_arb;
  localparam int TO = 8;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic        istb [2];
  logic [31:0] iadr [2];
  logic        dstb [2];
  logic        dwe  [2];
  logic [3:0]  dbe  [2];
  logic [31:0] dadr [2];
  logic [31:0] ddat [2];
  logic [31:0] mrd  [2];
  logic        mack [2];
  logic        iack [2];
  logic [31:0] irdat [2];
  logic        dack [2];
  logic [31:0] drdat [2];
  logic        mstb [2];
  logic        mwe  [2];
  logic [3:0]  mbe  [2];
  logic [31:0] madr [2];
  logic [31:0] mwdat [2];
  logic [1:0]  gnt  [2];
  logic        err  [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    exotiny_mem_arb #(.RR(k == 0 ? 1 : 0), .TIMEOUT(TO)) u_dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .imem_stb_i(istb[k]), .imem_adr_i(iadr[k]), .imem_ack_o(iack[k]), .imem_dat_o(irdat[k]),
      .dmem_stb_i(dstb[k]), .dmem_we_i(dwe[k]), .dmem_be_i(dbe[k]), .dmem_adr_i(dadr[k]),
      .dmem_dat_i(ddat[k]), .dmem_ack_o(dack[k]), .dmem_dat_o(drdat[k]),
      .mem_stb_o(mstb[k]), .mem_we_o(mwe[k]), .mem_be_o(mbe[k]), .mem_adr_o(madr[k]),
      .mem_dat_o(mwdat[k]), .mem_dat_i(mrd[k]), .mem_ack_i(mack[k]),
      .gnt_o(gnt[k]), .err_o(err[k])
    );
  end

  // Staged inputs, applied to one instance per tick.
  logic        s_is, s_ds, s_dw, s_ma;
  logic [31:0] s_ia, s_da, s_dd, s_md;
  logic [3:0]  s_db;

  // Reference model: owner of the shared memory (0 none, 1 imem, 2 dmem) and history.
  int   mg    [2];
  bit   mlast [2];   // 1: dmem was granted last
  int   mcnt  [2];   // grant cycles elapsed without ack
  bit   merr  [2];
  int   checks = 0;
  int   errors = 0;
  int   iack_n [2];
  int   dack_n [2];
  logic [1:0] pg [2];
  int   gseq [$];
  logic last_iack, last_dack;
  logic [31:0] last_irdat, last_drdat;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(logic is, logic [31:0] ia, logic ds, logic dw, logic [3:0] db,
                        logic [31:0] da, logic [31:0] dd, logic ma, logic [31:0] md);
    s_is = is; s_ia = ia; s_ds = ds; s_dw = dw; s_db = db;
    s_da = da; s_dd = dd; s_ma = ma; s_md = md;
  endtask

  task automatic check_dut(int d);
    int g;
    bit gs, hit, e_ia, e_da;
    logic [31:0] e_rd;
    g   = mg[d];
    gs  = (g == 1) ? bit'(istb[d]) : (g == 2) ? bit'(dstb[d]) : 1'b0;
    hit = 1'b0;
`ifdef EXOTINY_ARB_TIMEOUT_EN
    hit = gs && !mack[d] && (mcnt[d] + 1 == TO);
`endif
    e_ia = (g == 1) && istb[d] && (mack[d] || hit);
    e_da = (g == 2) && dstb[d] && (mack[d] || hit);
    e_rd = (g != 0 && !hit) ? mrd[d] : 32'h0;
    chk("gnt",      32'(gnt[d]),   32'(g == 1 ? 2'b01 : g == 2 ? 2'b10 : 2'b00));
    chk("mem_stb",  32'(mstb[d]),  32'(gs && !hit));
    chk("mem_we",   32'(mwe[d]),   32'(g == 2 && dwe[d]));
    chk("mem_be",   32'(mbe[d]),   32'(g == 1 ? 4'hF : g == 2 ? dbe[d] : 4'h0));
    chk("mem_adr",  madr[d],       g == 1 ? iadr[d] : g == 2 ? dadr[d] : 32'h0);
    chk("mem_dat",  mwdat[d],      g == 2 ? ddat[d] : 32'h0);
    chk("imem_ack", 32'(iack[d]),  32'(e_ia));
    chk("dmem_ack", 32'(dack[d]),  32'(e_da));
    chk("imem_dat", irdat[d],      e_rd);
    chk("dmem_dat", drdat[d],      e_rd);
    chk("err",      32'(err[d]),   32'(merr[d]));
    if (g == 0) begin
      if (istb[d] && dstb[d]) mg[d] = (d == 1 || mlast[d]) ? 1 : 2;
      else if (istb[d])       mg[d] = 1;
      else if (dstb[d])       mg[d] = 2;
      if (mg[d] != 0) begin
        mlast[d] = (mg[d] == 2);
        mcnt[d]  = 0;
      end
    end else if (!gs || mack[d] || hit) begin
      mg[d] = 0;
    end else begin
      mcnt[d]++;
    end
    if (hit) merr[d] = 1'b1;
  endtask

  task automatic tick(int d);
    @(negedge clk_i);
    istb[d] = s_is; iadr[d] = s_ia; dstb[d] = s_ds; dwe[d] = s_dw; dbe[d] = s_db;
    dadr[d] = s_da; ddat[d] = s_dd; mack[d] = s_ma; mrd[d] = s_md;
    #1;
    if (gnt[d] != 2'b00 && pg[d] == 2'b00) gseq.push_back(int'(gnt[d]));
    pg[d] = gnt[d];
    if (iack[d] === 1'b1) begin iack_n[d]++; last_irdat = irdat[d]; end
    if (dack[d] === 1'b1) begin dack_n[d]++; last_drdat = drdat[d]; end
    last_iack = iack[d];
    last_dack = dack[d];
    check_dut(d);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      istb[k] = 0; iadr[k] = 0; dstb[k] = 0; dwe[k] = 0; dbe[k] = 0;
      dadr[k] = 0; ddat[k] = 0; mrd[k] = 0; mack[k] = 0;
      mg[k] = 0; mlast[k] = 1'b1; mcnt[k] = 0; merr[k] = 1'b0;
      iack_n[k] = 0; dack_n[k] = 0; pg[k] = 2'b00;
    end
    gseq.delete();
    last_iack = 0; last_dack = 0; last_irdat = 0; last_drdat = 0;
    #1;
    for (int k = 0; k < 2; k++) check_dut(k);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0;
    do_reset();

    // Boot fetch with ack in the third grant cycle, then a mandatory idle cycle.
    set_in(1, 32'h1000_0000, 0, 0, 0, 0, 0, 0, 0);
    tick(0);
    tick(0);
    tick(0);
    set_in(1, 32'h1000_0000, 0, 0, 0, 0, 0, 1, 32'h0000_0013);
    tick(0);
    chk("t1_iack_pulses", 32'(iack_n[0]), 32'd1);
    chk("t1_rdata", last_irdat, 32'h0000_0013);
    set_in(1, 32'h1000_0004, 0, 0, 0, 0, 0, 0, 0);
    tick(0);
    chk("t1_idle_gap", 32'(gnt[0]), 32'd0);

    // Both ports hammering, round-robin: I, D, I, D.
    do_reset();
    set_in(1, 32'h100, 1, 0, 4'hF, 32'h200, 0, 1, 32'hA5A5_0000);
    repeat (8) tick(0);
    chk("t2_grants", 32'(gseq.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_order", 32'(gseq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

    // Fixed priority: imem wins every time, dmem served once imem goes quiet.
    do_reset();
    set_in(1, 32'h100, 1, 0, 4'hF, 32'h200, 0, 1, 32'h5A5A_0000);
    repeat (8) tick(1);
    set_in(0, 32'h100, 1, 0, 4'hF, 32'h200, 0, 1, 32'h5A5A_0001);
    repeat (2) tick(1);
    chk("t3_grants", 32'(gseq.size()), 32'd5);
    for (int i = 0; i < 4; i++) chk("t3_order", 32'(gseq[i]), 32'd1);
    chk("t3_dmem_last", 32'(gseq[4]), 32'd2);

    // dmem write arriving during an imem transaction waits for the imem ack.
    do_reset();
    set_in(1, 32'h1000_0010, 0, 0, 0, 0, 0, 0, 0);
    tick(0);
    tick(0);
    set_in(1, 32'h1000_0010, 1, 1, 4'b0011, 32'h40, 32'hCAFE_BABE, 0, 0);
    tick(0);
    tick(0);
    chk("t4_hold_adr", madr[0], 32'h1000_0010);
    set_in(1, 32'h1000_0010, 1, 1, 4'b0011, 32'h40, 32'hCAFE_BABE, 1, 32'h1234_5678);
    tick(0);
    set_in(0, 0, 1, 1, 4'b0011, 32'h40, 32'hCAFE_BABE, 0, 0);
    tick(0);
    tick(0);
    chk("t4_we", 32'(mwe[0]), 32'd1);
    chk("t4_be", 32'(mbe[0]), 32'h3);
    chk("t4_wdat", mwdat[0], 32'hCAFE_BABE);
    set_in(1, 32'h1000_0014, 1, 1, 4'b0011, 32'h40, 32'hCAFE_BABE, 1, 0);
    tick(0);
    chk("t4_iack_blocked", 32'(iack[0]), 32'd0);
    chk("t4_dack", 32'(dack[0]), 32'd1);

    // dmem abort followed by a late downstream ack.
    do_reset();
    set_in(0, 0, 1, 0, 4'hF, 32'h80, 0, 0, 0);
    tick(0);
    tick(0);
    set_in(0, 0, 0, 0, 4'hF, 32'h80, 0, 0, 0);
    tick(0);
    chk("t5_stb_drop", 32'(mstb[0]), 32'd0);
    set_in(0, 0, 0, 0, 4'hF, 32'h80, 0, 1, 32'hDEAD_BEEF);
    tick(0);
    chk("t5_idle", 32'(gnt[0]), 32'd0);
    chk("t5_no_ack", 32'(iack_n[0] + dack_n[0]), 32'd0);

`ifdef EXOTINY_ARB_TIMEOUT_EN
    // Watchdog: no ack at all on a dmem read.
    do_reset();
    set_in(0, 0, 1, 0, 4'hF, 32'h90, 0, 0, 32'h7777_7777);
    tick(0);
    repeat (TO) tick(0);
    chk("t6_dack_pulses", 32'(dack_n[0]), 32'd1);
    chk("t6_rdata_zero", last_drdat, 32'h0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0);
    chk("t6_err_set", 32'(err[0]), 32'd1);
    set_in(1, 32'h1000_0020, 0, 0, 0, 0, 0, 0, 0);
    tick(0);
    tick(0);
    chk("t6_regrant", 32'(gnt[0]), 32'd1);
    chk("t6_err_sticky", 32'(err[0]), 32'd1);
`endif

    // Random traffic with random ack latency, aborts and stray acks.
    for (int d = 0; d < 2; d++) begin
      do_reset();
      for (int n = 0; n < 400; n++) begin
        if (s_is) begin
          if (last_iack || $urandom_range(15) == 0) s_is = 1'b0;
        end else if ($urandom_range(1) == 1) begin
          s_is = 1'b1;
          s_ia = $urandom;
        end
        if (s_ds) begin
          if (last_dack || $urandom_range(15) == 0) s_ds = 1'b0;
        end else if ($urandom_range(1) == 1) begin
          s_ds = 1'b1;
          s_dw = 1'($urandom_range(1));
          s_db = 4'($urandom_range(15));
          s_da = $urandom;
          s_dd = $urandom;
        end
        s_ma = ($urandom_range(2) == 0);
        s_md = $urandom;
        tick(d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
